// File: rtl/lp_filter_chain_pkg.sv
// Shared definitions for the lp_filter_chain family: FSM encodings, SHIFT port
// width and width helpers used by the top level and the shared filter ALU.
package lp_filter_chain_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } fsm_state_e;

  localparam int SHIFT_W = 4;

  // State keeps MAX_SHIFT fraction bits below the integer sample bits.
  function automatic int state_width(input int in_bits, input int max_shift);
    return in_bits + max_shift;
  endfunction

  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lp_filter_chain_alu.sv
// Combinational first-order low-pass step: next = state + ((x<<MAX_SHIFT) - state) >>> shift.
// Shared by the filter variants; holds no state of its own.
module lp_filter_chain_alu
  import lp_filter_chain_pkg::*;
#(
  parameter int IN_DATA_BITS = 28,
  parameter int MAX_SHIFT    = 8,
  parameter int SW           = IN_DATA_BITS + MAX_SHIFT
) (
  input  logic [IN_DATA_BITS-1:0] x,
  input  logic [SW-1:0]           state,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [SW-1:0]           next_state
);

  logic [SW-1:0]        x_scaled;
  logic signed [SW:0]   diff;
  logic signed [SW:0]   step;

  // Arithmetic shift floors toward -inf, so the result stays between state and x.
  always_comb begin
    x_scaled   = SW'(x) << MAX_SHIFT;
    diff       = $signed({1'b0, x_scaled}) - $signed({1'b0, state});
    step       = diff >>> shift;
    next_state = SW'($signed({1'b0, state}) + step);
  end

endmodule

// File: rtl/lp_filter_chain.sv
// Time-multiplexed multi-channel cascade of exponential low-pass stages.
// Optional macro LP_FILTER_PRELOAD_EN: first sample of a channel preloads all its stages.
module lp_filter_chain
  import lp_filter_chain_pkg::*;
#(
  parameter int IN_DATA_BITS  = 28,
  parameter int OUT_DATA_BITS = 28,
  parameter int MAX_SHIFT     = 8,
  parameter int STAGES        = 2,
  parameter int CHANNELS      = 4,
  parameter int CH_BITS       = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CE,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [CH_BITS-1:0]       IN_CHANNEL,
  input  logic [IN_DATA_BITS-1:0]  IN_VALUE,
  input  logic [SHIFT_W-1:0]       SHIFT,
  output logic                     OUT_VALID,
  output logic [CH_BITS-1:0]       OUT_CHANNEL,
  output logic [OUT_DATA_BITS-1:0] OUT_VALUE
);

  localparam int SW      = state_width(IN_DATA_BITS, MAX_SHIFT);
  localparam int ENTRIES = CHANNELS * STAGES;
  localparam int ADDR_W  = min_width(ENTRIES);
  localparam int ST_W    = min_width(STAGES);

  localparam logic [ADDR_W-1:0]  LAST_ENTRY = ADDR_W'(ENTRIES - 1);
  localparam logic [ST_W-1:0]    LAST_STAGE = ST_W'(STAGES - 1);
  localparam logic [CH_BITS:0]   CH_LIMIT   = (CH_BITS + 1)'(CHANNELS);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX  = SHIFT_W'(MAX_SHIFT);

  fsm_state_e                state_q, state_d;
  logic [ADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
  logic [ST_W-1:0]           stage_q, stage_d;
  logic [CH_BITS-1:0]        ch_q, ch_d;
  logic [IN_DATA_BITS-1:0]   val_q, val_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]        out_channel_q, out_channel_d;
  logic [OUT_DATA_BITS-1:0]  out_value_q, out_value_d;

  logic [SW-1:0]             mem_q [ENTRIES];
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [SW-1:0]             mem_wdata;

  logic [ADDR_W-1:0]         cur_addr;
  logic [ADDR_W-1:0]         prev_addr;
  logic [IN_DATA_BITS-1:0]   alu_x;
  logic [SW-1:0]             alu_next;
  logic [SHIFT_W-1:0]        shift_clamped;
  logic                      accept;
  logic                      ch_legal;

`ifdef LP_FILTER_PRELOAD_EN
  logic [CHANNELS-1:0]       primed_q, primed_d;
  logic                      primed_hit;
`endif

  // Address and operand selection for the stage currently being processed.
  always_comb begin
    cur_addr      = ADDR_W'(int'(ch_q) * STAGES + int'(stage_q));
    prev_addr     = cur_addr - ADDR_W'(1);
    shift_clamped = (SHIFT > SHIFT_MAX) ? SHIFT_MAX : SHIFT;
    accept        = CE & IN_VALID & in_ready_q;
    ch_legal      = ({1'b0, IN_CHANNEL} < CH_LIMIT);
    if (stage_q == '0) begin
      alu_x = val_q;
    end else begin
      alu_x = mem_q[prev_addr][SW-1:MAX_SHIFT];
    end
  end

  lp_filter_chain_alu #(
    .IN_DATA_BITS (IN_DATA_BITS),
    .MAX_SHIFT    (MAX_SHIFT),
    .SW           (SW)
  ) u_alu (
    .x          (alu_x),
    .state      (mem_q[cur_addr]),
    .shift      (shift_q),
    .next_state (alu_next)
  );

`ifdef LP_FILTER_PRELOAD_EN
  // Priming lookup for the channel in flight.
  always_comb begin
    primed_hit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CH_BITS'(c)) begin
        primed_hit = primed_q[c];
      end else begin
        primed_hit = primed_hit;
      end
    end
  end
`endif

  // Next-state, state-array write port and output register inputs.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    stage_d       = stage_q;
    ch_d          = ch_q;
    val_d         = val_q;
    shift_d       = shift_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = 1'b0;
    out_channel_d = out_channel_q;
    out_value_d   = out_value_q;
    mem_we        = 1'b0;
    mem_addr      = cur_addr;
    mem_wdata     = alu_next;
`ifdef LP_FILTER_PRELOAD_EN
    primed_d      = primed_q;
`endif

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == LAST_ENTRY) begin
          clr_cnt_d  = '0;
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end else begin
          clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        // Out-of-range channels are consumed without touching any state.
        if (accept && ch_legal) begin
          ch_d       = IN_CHANNEL;
          val_d      = IN_VALUE;
          shift_d    = shift_clamped;
          stage_d    = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        mem_we = 1'b1;
`ifdef LP_FILTER_PRELOAD_EN
        if (!primed_hit) begin
          mem_wdata = SW'(val_q) << MAX_SHIFT;
        end else begin
          mem_wdata = alu_next;
        end
`endif
        if (stage_q == LAST_STAGE) begin
          state_d       = ST_IDLE;
          in_ready_d    = 1'b1;
          out_valid_d   = 1'b1;
          out_channel_d = ch_q;
          out_value_d   = mem_wdata[SW-1 -: OUT_DATA_BITS];
`ifdef LP_FILTER_PRELOAD_EN
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CH_BITS'(c)) begin
              primed_d[c] = 1'b1;
            end else begin
              primed_d[c] = primed_q[c];
            end
          end
`endif
        end else begin
          stage_d = stage_q + ST_W'(1);
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_cnt_d  = '0;
        in_ready_d = 1'b0;
      end
    endcase
  end

  // Control and output registers; CE=0 freezes everything, reset wins over CE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      stage_q       <= '0;
      ch_q          <= '0;
      val_q         <= '0;
      shift_q       <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_value_q   <= '0;
`ifdef LP_FILTER_PRELOAD_EN
      primed_q      <= '0;
`endif
    end else if (CE) begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      stage_q       <= stage_d;
      ch_q          <= ch_d;
      val_q         <= val_d;
      shift_q       <= shift_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_value_q   <= out_value_d;
`ifdef LP_FILTER_PRELOAD_EN
      primed_q      <= primed_d;
`endif
    end
  end

  // Per-(channel, stage) state array; cleared by walking ST_CLEAR, not by reset.
  always_ff @(posedge CLK) begin
    if (!RESET && CE && mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_CHANNEL = out_channel_q;
  assign OUT_VALUE   = out_value_q;

endmodule

// File: tb/tb_lp_filter_chain.sv
// Directed self-checking bench for lp_filter_chain (8-bit samples, MAX_SHIFT=4,
// STAGES=2, CHANNELS=4); expected values are hand-computed filter results.
module tb_lp_filter_chain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_channel = 4'd0;
  logic [7:0] in_value = 8'd0;
  logic [3:0] shift = 4'd0;
  logic       out_valid;
  logic [3:0] out_channel;
  logic [7:0] out_value;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lp_filter_chain #(
    .IN_DATA_BITS  (8),
    .OUT_DATA_BITS (8),
    .MAX_SHIFT     (4),
    .STAGES        (2),
    .CHANNELS      (4),
    .CH_BITS       (4)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .CE          (ce),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .IN_CHANNEL  (in_channel),
    .IN_VALUE    (in_value),
    .SHIFT       (shift),
    .OUT_VALID   (out_valid),
    .OUT_CHANNEL (out_channel),
    .OUT_VALUE   (out_value)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reset pulse, then count the cycles spent clearing the state array.
  task automatic do_reset(input string tag);
    int n;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_value"}, 32'(out_value), 32'd0);
    check_eq({tag, "_chan"},  32'(out_channel), 32'd0);
    check_eq({tag, "_rdy0"},  32'(in_ready), 32'd0);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_clear_cycles"}, 32'(n), 32'd8);
  endtask

  // One sample: wait ready, handshake, optionally drop CE for gap cycles in RUN.
  task automatic send(input string tag, input int ch, input int val, input int sh,
                      input int gap, input int exp_val, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_channel = 4'(ch);
    in_value   = 8'(val);
    shift      = 4'(sh);
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (gap > 0 && lat == 1) ce = 1'b0;
      if (gap > 0 && lat == 1 + gap) ce = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    ce = 1'b1;
    check_eq({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check_eq({tag, "_value"}, 32'(out_value), 32'(exp_val));
    check_eq({tag, "_chan"},  32'(out_channel), 32'(ch));
  endtask

  initial begin
    int  n;
    logic seen;
    logic rdy_all;

    do_reset("reset");

    // Step response, 2 stages, SHIFT=1, input 200.
    send("step1", 0, 200, 1, 0, 50, 2);
    send("step2", 0, 200, 1, 0, 100, 2);

    // Illegal channel: consumed, no result, ready stays high.
    check_eq("illegal_rdy_before", 32'(in_ready), 32'd1);
    in_channel = 4'd7; in_value = 8'd55; shift = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0; rdy_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen    = seen | out_valid;
      rdy_all = rdy_all & in_ready;
      @(posedge clk); #1;
    end
    check_eq("illegal_no_valid", 32'(seen), 32'd0);
    check_eq("illegal_ready_high", 32'(rdy_all), 32'd1);

    // Channel 0 state untouched by the dropped sample.
    send("step3", 0, 200, 1, 0, 137, 2);
    // CE low for 5 cycles mid-RUN stretches latency by 5, same result.
    send("step4_ce", 0, 200, 1, 5, 162, 7);

    // OUT_VALID held while CE is low, cleared by the next enabled edge.
    ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("valid_hold_ce0", 32'(out_valid), 32'd1);
    ce = 1'b1;
    @(posedge clk); #1;
    check_eq("valid_pulse_end", 32'(out_valid), 32'd0);

    // SHIFT=0 pass-through.
    send("pass1", 2, 8'h5A, 0, 0, 8'h5A, 2);
    send("pass2", 2, 8'h11, 0, 0, 8'h11, 2);

    // Channel isolation: ch3 steps toward 100, ch1 fed zeros stays at zero.
    send("iso_ch3_a", 3, 100, 2, 0, 6, 2);
    send("iso_ch1_a", 1, 0, 2, 0, 0, 2);
    send("iso_ch3_b", 3, 100, 2, 0, 15, 2);
    send("iso_ch1_b", 1, 0, 2, 0, 0, 2);

    // SHIFT=15 clamps to MAX_SHIFT=4.
    send("clamp_a", 1, 255, 15, 0, 0, 2);
    send("clamp_b", 1, 255, 15, 0, 2, 2);
    send("clamp_c", 1, 255, 15, 0, 5, 2);

    // Reset during RUN aborts the sample and re-runs the clear sweep.
    check_eq("midrst_rdy", 32'(in_ready), 32'd1);
    in_channel = 4'd0; in_value = 8'd200; shift = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_rdy_low", 32'(in_ready), 32'd0);
    seen = out_valid;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
      n++;
    end
    check_eq("midrst_no_valid", 32'(seen), 32'd0);
    check_eq("midrst_clear_cycles", 32'(n), 32'd8);

    // Channel 0 restarts from the cleared state.
    send("after_rst", 0, 200, 1, 0, 50, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
